coprocessor0_regfile: RTL and testbench

//  CP0 register file and exception sequencer. Takes commit-time exception, ERET and MTC0/MFC0 requests

---
 rtl/coprocessor0_regfile.sv | 158 +++++++++++++++
 tb/tb_coprocessor0_regfile.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coprocessor0_regfile.sv
// CP0 register file: BadVAddr/Count/Compare/Status/Cause/EPC, the Count/Compare timer,
// commit-time exception/ERET sequencing and the fetch-redirect/interrupt bus toward IF.
module coprocessor0_regfile #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  ext_int,
    input  logic        wb_valid,
    input  logic        wb_exception,
    input  logic [4:0]  wb_exc_code,
    input  logic        wb_in_delay_slot,
    input  logic [31:0] wb_pc,
    input  logic        wb_badvaddr_we,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_eret,
    input  logic        wb_mtc0,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] exception_address,
    output logic [7:0]  interrupt_valid
);
    localparam logic [7:0] A_BADVADDR = 8'h40;
    localparam logic [7:0] A_COUNT    = 8'h48;
    localparam logic [7:0] A_COMPARE  = 8'h58;
    localparam logic [7:0] A_STATUS   = 8'h60;
    localparam logic [7:0] A_CAUSE    = 8'h68;
    localparam logic [7:0] A_EPC      = 8'h70;
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d, epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d;
    logic        bd_q, bd_d, ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic        flush_q, flush_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    // wb_valid qualifies every wb_* request; a commit is accepted unconditionally in its cycle.
    logic exc_fire, eret_fire, mtc0_fire, tick;
    assign exc_fire  = wb_valid & wb_exception;
    assign eret_fire = wb_valid & wb_eret & ~wb_exception;
    assign mtc0_fire = wb_valid & wb_mtc0 & ~wb_exception;
    assign tick      = (div_q == DIV_W'(COUNT_DIV - 1));

    always_comb begin
        div_d      = tick ? '0 : div_q + 1'b1;
        badvaddr_d = badvaddr_q;
        count_d    = tick ? count_q + 32'd1 : count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q | (count_q == compare_q);
        ip_hw_d    = {ext_int[5] | ti_q, ext_int[4:0]};
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        flush_d    = exc_fire | eret_fire;
        exc_addr_d = exc_addr_q;

        if (mtc0_fire) begin
            case (cp0_addr)
                A_COUNT:   count_d = cp0_wdata;
                A_COMPARE: begin
                    compare_d = cp0_wdata;
                    ti_d      = 1'b0;
                end
                A_STATUS:  begin
                    im_d  = cp0_wdata[15:8];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                A_CAUSE:   ip_sw_d = cp0_wdata[9:8];
                A_EPC:     epc_d = cp0_wdata;
                default:   ;
            endcase
        end

        if (eret_fire) begin
            exl_d      = 1'b0;
            exc_addr_d = epc_q;
        end

        // A nested exception (EXL already set) keeps the original return point.
        if (exc_fire) begin
            if (!exl_q) begin
                epc_d = wb_in_delay_slot ? wb_pc - 32'd4 : wb_pc;
                bd_d  = wb_in_delay_slot;
            end
            exl_d      = 1'b1;
            exc_code_d = wb_exc_code;
            if (wb_badvaddr_we) badvaddr_d = wb_badvaddr;
            exc_addr_d = EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
            flush_q    <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            div_q      <= div_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            flush_q    <= flush_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_addr)
            A_BADVADDR: cp0_rdata = badvaddr_q;
            A_COUNT:    cp0_rdata = count_q;
            A_COMPARE:  cp0_rdata = compare_q;
            A_STATUS:   cp0_rdata = {9'h0, 1'b1, 6'h0, im_q, 6'h0, exl_q, ie_q};
            A_CAUSE:    cp0_rdata = {bd_q, ti_q, 14'h0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};
            A_EPC:      cp0_rdata = epc_q;
            default:    cp0_rdata = 32'h0;
        endcase
    end

    assign flush             = flush_q;
    assign exception_address = exc_addr_q;
    assign interrupt_valid   = {ip_hw_q, ip_sw_q} & im_q & {8{ie_q & ~exl_q}};

endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Directed bench for coprocessor0_regfile: driver tasks push expectations, a negedge
// monitor pops and compares register reads, interrupt lines and flush redirects.
module tb_coprocessor0_regfile;
    localparam logic [7:0] A_BADVADDR = 8'h40;
    localparam logic [7:0] A_COUNT    = 8'h48;
    localparam logic [7:0] A_COMPARE  = 8'h58;
    localparam logic [7:0] A_STATUS   = 8'h60;
    localparam logic [7:0] A_CAUSE    = 8'h68;
    localparam logic [7:0] A_EPC      = 8'h70;
    localparam logic [31:0] VEC       = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  ext_int;
    logic        wb_valid, wb_exception, wb_in_delay_slot, wb_badvaddr_we, wb_eret, wb_mtc0;
    logic [4:0]  wb_exc_code;
    logic [31:0] wb_pc, wb_badvaddr, cp0_wdata;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_rdata, exception_address;
    logic        flush;
    logic [7:0]  interrupt_valid;

    always #5 clk = ~clk;

    coprocessor0_regfile dut (
        .clk(clk), .resetn(resetn), .ext_int(ext_int),
        .wb_valid(wb_valid), .wb_exception(wb_exception), .wb_exc_code(wb_exc_code),
        .wb_in_delay_slot(wb_in_delay_slot), .wb_pc(wb_pc),
        .wb_badvaddr_we(wb_badvaddr_we), .wb_badvaddr(wb_badvaddr),
        .wb_eret(wb_eret), .wb_mtc0(wb_mtc0), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .flush(flush), .exception_address(exception_address),
        .interrupt_valid(interrupt_valid)
    );

    typedef struct {
        int          kind;
        logic [31:0] exp;
        int          id;
    } chk_t;

    chk_t        exp_q[$];
    logic [31:0] fl_q[$];
    logic        chk_req = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          id_n = 0;
    chk_t        mon_c;
    logic [31:0] mon_act;
    logic [31:0] mon_fl;

    function automatic string kind_name(input int k);
        if (k == 0) return "rdata";
        if (k == 1) return "irq";
        return "exc_addr";
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_wb();
        wb_valid = 0; wb_exception = 0; wb_exc_code = 0; wb_in_delay_slot = 0;
        wb_pc = 0; wb_badvaddr_we = 0; wb_badvaddr = 0; wb_eret = 0; wb_mtc0 = 0;
        cp0_wdata = 0;
    endtask

    task automatic push_chk(input int kind, input logic [31:0] e);
        chk_t c;
        c.kind = kind; c.exp = e; c.id = id_n;
        id_n = id_n + 1;
        exp_q.push_back(c);
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic mfc0(input logic [7:0] addr, input logic [31:0] e);
        cp0_addr = addr;
        push_chk(0, e);
    endtask

    task automatic chk_iv(input logic [7:0] e);
        push_chk(1, {24'h0, e});
    endtask

    task automatic chk_addr(input logic [31:0] e);
        push_chk(2, e);
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] d);
        wb_valid = 1; wb_mtc0 = 1; cp0_addr = addr; cp0_wdata = d;
        @(posedge clk); #1;
        clear_wb();
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                       input logic bv_we, input logic [31:0] bv);
        wb_valid = 1; wb_exception = 1; wb_exc_code = code; wb_pc = pc;
        wb_in_delay_slot = ds; wb_badvaddr_we = bv_we; wb_badvaddr = bv;
        fl_q.push_back(VEC);
        @(posedge clk); #1;
        clear_wb();
    endtask

    task automatic eret(input logic [31:0] exp_epc);
        wb_valid = 1; wb_eret = 1;
        fl_q.push_back(exp_epc);
        @(posedge clk); #1;
        clear_wb();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (chk_req) begin
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL scoreboard: check strobe with empty expected queue");
            end else begin
                mon_c = exp_q.pop_front();
                if (mon_c.kind == 0)      mon_act = cp0_rdata;
                else if (mon_c.kind == 1) mon_act = {24'h0, interrupt_valid};
                else                      mon_act = exception_address;
                if (mon_act !== mon_c.exp) begin
                    fails = fails + 1;
                    $display("FAIL %s#%0d (addr %h): got %h expected %h",
                             kind_name(mon_c.kind), mon_c.id, cp0_addr, mon_act, mon_c.exp);
                end
            end
        end
        if (flush !== 1'b0) begin
            tests = tests + 1;
            if (fl_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL flush: unexpected pulse, flush=%b exception_address=%h",
                         flush, exception_address);
            end else begin
                mon_fl = fl_q.pop_front();
                if (flush !== 1'b1 || exception_address !== mon_fl) begin
                    fails = fails + 1;
                    $display("FAIL flush_target: got %h expected %h", exception_address, mon_fl);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn = 0; ext_int = 0; cp0_addr = 0;
        clear_wb();
        repeat (3) @(posedge clk);
        #1;
        // reset state, read while reset is still held
        mfc0(A_STATUS, 32'h0040_0000);
        mfc0(A_CAUSE,  32'h0000_0000);
        mfc0(A_EPC,    32'h0000_0000);
        chk_iv(8'h00);
        chk_addr(32'h0);
        resetn = 1;

        // masked Status write, unmapped address, read-only BadVAddr
        mtc0(A_COMPARE, 32'h1000_0000);
        mtc0(A_STATUS, 32'hFFFF_FFFF);
        mfc0(A_STATUS, 32'h0040_FF03);
        mtc0(A_STATUS, 32'h0);
        mfc0(A_STATUS, 32'h0040_0000);
        mtc0(A_BADVADDR, 32'hDEAD_BEEF);
        mfc0(A_BADVADDR, 32'h0);
        mtc0(8'h61, 32'h1234_5678);
        mfc0(8'h61, 32'h0);
        mfc0(A_COMPARE, 32'h1000_0000);

        // exception in a delay slot with a faulting address
        exc(5'd4, 32'h8000_1004, 1'b1, 1'b1, 32'h0000_0003);
        mfc0(A_EPC,      32'h8000_1000);
        mfc0(A_CAUSE,    32'h8000_0010);
        mfc0(A_BADVADDR, 32'h0000_0003);
        mfc0(A_STATUS,   32'h0040_0002);

        // nested exception keeps EPC/BD, then ERET returns to EPC
        exc(5'd5, 32'h8000_2000, 1'b0, 1'b0, 32'h0);
        mfc0(A_EPC,   32'h8000_1000);
        mfc0(A_CAUSE, 32'h8000_0014);
        eret(32'h8000_1000);
        mfc0(A_STATUS, 32'h0040_0000);

        // timer wrap and TI through IP7
        mtc0(A_COMPARE, 32'h0);
        mtc0(A_STATUS, 32'h0000_8001);
        mtc0(A_COUNT, 32'hFFFF_FFFE);
        repeat (6) @(posedge clk);
        #1;
        chk_iv(8'h80);
        mfc0(A_CAUSE, 32'hC000_8014);
        mtc0(A_COMPARE, 32'd5);
        @(posedge clk); #1;
        chk_iv(8'h00);
        mfc0(A_CAUSE, 32'h8000_0014);
        mtc0(A_COMPARE, 32'h8000_0000);

        // external interrupt line 0 through IM2, then masked by EXL
        mtc0(A_STATUS, 32'h0000_0401);
        ext_int = 6'h01;
        @(posedge clk); #1;
        chk_iv(8'h04);
        mtc0(A_STATUS, 32'h0000_0403);
        chk_iv(8'h00);
        mtc0(A_STATUS, 32'h0);
        ext_int = 6'h00;
        @(posedge clk); #1;

        // exception and MTC0 Status in the same commit
        wb_valid = 1; wb_exception = 1; wb_exc_code = 5'd8; wb_pc = 32'h8000_3000;
        wb_mtc0 = 1; cp0_addr = A_STATUS; cp0_wdata = 32'h0000_FF01;
        fl_q.push_back(VEC);
        @(posedge clk); #1;
        clear_wb();
        mfc0(A_STATUS, 32'h0040_0002);
        mfc0(A_EPC,    32'h8000_3000);
        mfc0(A_CAUSE,  32'h0000_0020);

        // reset while a flush is pending and another exception commits
        exc(5'd4, 32'h8000_4000, 1'b0, 1'b0, 32'h0);
        resetn = 0;
        wb_valid = 1; wb_exception = 1; wb_exc_code = 5'd4; wb_pc = 32'h8000_5000;
        @(posedge clk); #1;
        clear_wb();
        chk_addr(32'h0);
        mfc0(A_STATUS, 32'h0040_0000);
        mfc0(A_EPC,    32'h0);
        resetn = 1;
        repeat (4) @(posedge clk);
        #1;

        tests = tests + 1;
        if (exp_q.size() != 0 || fl_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: pending checks=%0d pending flushes=%0d, expected 0 and 0",
                     exp_q.size(), fl_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
